// File: rtl/traffic_pkg.sv
// traffic_pkg: shared interval codes, lamp encodings, state enum and default times
package traffic_pkg;
    localparam logic [1:0] INT_BASE = 2'b00;
    localparam logic [1:0] INT_EXT  = 2'b01;
    localparam logic [1:0] INT_YEL  = 2'b10;
    localparam logic [2:0] LAMP_R = 3'b100;
    localparam logic [2:0] LAMP_Y = 3'b010;
    localparam logic [2:0] LAMP_G = 3'b001;
    localparam logic [3:0] T_BASE_DEF = 4'd6;
    localparam logic [3:0] T_EXT_DEF  = 4'd3;
    localparam logic [3:0] T_YEL_DEF  = 4'd2;
    localparam int SETTLE_CYC_DEF = 2;

    typedef enum logic [2:0] {MG_BASE, MG_EXT, MY, WALK, SG, SY} state_t;

    function automatic logic [1:0] interval_of(input state_t s);
        return (s == MY || s == SY) ? INT_YEL : (s == MG_EXT || s == WALK) ? INT_EXT : INT_BASE;
    endfunction

    function automatic logic [2:0] main_lamp(input state_t s);
        return (s == MG_BASE || s == MG_EXT) ? LAMP_G : (s == MY) ? LAMP_Y : LAMP_R;
    endfunction

    function automatic logic [2:0] side_lamp(input state_t s);
        return (s == SG) ? LAMP_G : (s == SY) ? LAMP_Y : LAMP_R;
    endfunction
endpackage

// File: rtl/interval_countdown.sv
// interval_countdown: settle wait, zero-clamped load and 1 Hz countdown with expiry pulse
module interval_countdown
    import traffic_pkg::*;
#(
    parameter int SETTLE_CYC = SETTLE_CYC_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clear,
    input  logic       tick,
    input  logic [3:0] value,
    output logic [3:0] cnt,
    output logic       expired
);
    localparam int SW = $clog2(SETTLE_CYC + 1);

    logic [SW-1:0] settle_cnt;

    assign expired = tick && settle_cnt == '0 && cnt == 4'd1;

    // settle after each restart, load the fetched length, then count ticks; cnt parks at 1 across a transition
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            settle_cnt <= SW'(SETTLE_CYC);
            cnt        <= '0;
        end else if (expired) begin
            settle_cnt <= SW'(SETTLE_CYC);
        end else if (settle_cnt != '0) begin
            settle_cnt <= settle_cnt - SW'(1);
            if (settle_cnt == SW'(1))
                cnt <= (value == 4'd0) ? 4'd1 : value;
        end else if (tick && cnt != 4'd1) begin
            cnt <= cnt - 4'd1;
        end
    end
endmodule

// File: rtl/light_sequencer_fsm.sv
// light_sequencer_fsm: intersection sequencer driving lamps and the timing-store interval select
module light_sequencer_fsm
    import traffic_pkg::*;
#(
    parameter int SETTLE_CYC = SETTLE_CYC_DEF
) (
    input  logic       clk,
    input  logic       Sync_Reset,
    input  logic       one_hz_en,
    input  logic       Sync_Reprogram,
    input  logic       Sync_Sensor,
    input  logic       Sync_Walk_Request,
    input  logic [3:0] Value,
    output logic [1:0] Interval,
    output logic [2:0] Main_Lights,
    output logic [2:0] Side_Lights,
    output logic       Walk_Light,
    output logic [3:0] Time_Left
);
    state_t state, succ, state_d;
    logic   expired, take, sens_lat, walk_lat;

    interval_countdown #(.SETTLE_CYC(SETTLE_CYC)) u_countdown (
        .clk     (clk),
        .rst     (Sync_Reset),
        .clear   (Sync_Reprogram),
        .tick    (one_hz_en),
        .value   (Value),
        .cnt     (Time_Left),
        .expired (expired)
    );

    // successor on expiry; reprogram restarts at MG_BASE and beats a coincident expiry
    always_comb begin
        succ = MG_BASE;
        case (state)
            MG_BASE: succ = sens_lat ? MG_EXT : MY;
            MG_EXT:  succ = MY;
            MY:      succ = walk_lat ? WALK : SG;
            WALK:    succ = SG;
            SG:      succ = SY;
            SY:      succ = MG_BASE;
            default: succ = MG_BASE;
        endcase
        take    = expired && !Sync_Reprogram;
        state_d = Sync_Reprogram ? MG_BASE : take ? succ : state;
    end

    // state register with lamps and interval decoded from the next state so they change on the same edge
    always_ff @(posedge clk) begin
        if (Sync_Reset) begin
            state       <= MG_BASE;
            Interval    <= INT_BASE;
            Main_Lights <= LAMP_G;
            Side_Lights <= LAMP_R;
            Walk_Light  <= 1'b0;
        end else begin
            state       <= state_d;
            Interval    <= interval_of(state_d);
            Main_Lights <= main_lamp(state_d);
            Side_Lights <= side_lamp(state_d);
            Walk_Light  <= state_d == WALK;
        end
    end

    // request latches survive reprogram; clearing on the consuming edge wins over a fresh request
    always_ff @(posedge clk) begin
        if (Sync_Reset) begin
            sens_lat <= 1'b0;
            walk_lat <= 1'b0;
        end else begin
            sens_lat <= (take && (state == MG_EXT || (state == MG_BASE && succ == MY))) ? 1'b0 :
                        sens_lat | (Sync_Sensor && state == MG_BASE);
            walk_lat <= (take && succ == WALK) ? 1'b0 : walk_lat | (Sync_Walk_Request && state != WALK);
        end
    end
endmodule

// File: tb/tb_light_sequencer_fsm.sv
// tb_light_sequencer_fsm: phase-table and directed-sequence checks of the light sequencer
module tb_light_sequencer_fsm;
    logic       clk = 1'b0;
    logic       Sync_Reset = 1'b1, one_hz_en = 1'b0, Sync_Reprogram = 1'b0;
    logic       Sync_Sensor = 1'b0, Sync_Walk_Request = 1'b0;
    logic [3:0] Value = 4'd0;
    logic [1:0] Interval;
    logic [2:0] Main_Lights, Side_Lights;
    logic       Walk_Light;
    logic [3:0] Time_Left;

    logic [3:0] t_base = 4'd6, t_ext = 4'd3, t_yel = 4'd2;
    int mode = 0, ph = 0, total = 0, passed = 0;

    typedef struct {
        logic       sens;
        logic       wreq;
        logic [1:0] intv;
        logic [2:0] ml;
        logic [2:0] sl;
        logic       wl;
        int         ticks;
    } phase_t;

    phase_t tbl[17];

    light_sequencer_fsm dut (
        .clk               (clk),
        .Sync_Reset        (Sync_Reset),
        .one_hz_en         (one_hz_en),
        .Sync_Reprogram    (Sync_Reprogram),
        .Sync_Sensor       (Sync_Sensor),
        .Sync_Walk_Request (Sync_Walk_Request),
        .Value             (Value),
        .Interval          (Interval),
        .Main_Lights       (Main_Lights),
        .Side_Lights       (Side_Lights),
        .Walk_Light        (Walk_Light),
        .Time_Left         (Time_Left)
    );

    always #5 clk = ~clk;

    // parameter store model: one registered cycle from Interval to Value
    always @(posedge clk)
        Value <= (Interval == 2'b00) ? t_base : (Interval == 2'b01) ? t_ext : (Interval == 2'b10) ? t_yel : 4'd0;

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    endtask

    task automatic clk1();
        one_hz_en = (mode == 2) || (mode == 1 && ph == 3);
        @(posedge clk);
        #1;
        ph = (ph + 1) % 4;
    endtask

    task automatic chk_out(input string nm, input logic [1:0] iv, input logic [2:0] ml, input logic [2:0] sl, input logic wl);
        chk({nm, " interval"}, Interval, iv);
        chk({nm, " main"}, Main_Lights, ml);
        chk({nm, " side"}, Side_Lights, sl);
        chk({nm, " walk"}, Walk_Light, wl);
    endtask

    task automatic run_phase(input phase_t p, input string nm);
        int k = 0, n = 0;
        logic done = 1'b0;
        chk_out(nm, p.intv, p.ml, p.sl, p.wl);
        while (!done && n < 400) begin
            Sync_Sensor       = (n == 0) && p.sens;
            Sync_Walk_Request = (n == 0) && p.wreq;
            if (mode == 1 && ph == 3) begin
                if (k < p.ticks) chk($sformatf("%s time_left tick%0d", nm, k), Time_Left, p.ticks - k);
                k++;
            end
            clk1();
            n++;
            done = {Interval, Main_Lights, Side_Lights, Walk_Light} != {p.intv, p.ml, p.sl, p.wl};
        end
        Sync_Sensor = 1'b0;
        Sync_Walk_Request = 1'b0;
        chk({nm, " ended"}, done, 1);
        chk({nm, " ticks"}, k, p.ticks);
    endtask

    initial begin
        int n;
        tbl[0]  = '{0, 0, 2'b00, 3'b001, 3'b100, 0, 6};
        tbl[1]  = '{0, 0, 2'b10, 3'b010, 3'b100, 0, 2};
        tbl[2]  = '{0, 0, 2'b00, 3'b100, 3'b001, 0, 6};
        tbl[3]  = '{0, 0, 2'b10, 3'b100, 3'b010, 0, 2};
        tbl[4]  = '{1, 0, 2'b00, 3'b001, 3'b100, 0, 6};
        tbl[5]  = '{0, 0, 2'b01, 3'b001, 3'b100, 0, 3};
        tbl[6]  = '{0, 0, 2'b10, 3'b010, 3'b100, 0, 2};
        tbl[7]  = '{0, 1, 2'b00, 3'b100, 3'b001, 0, 6};
        tbl[8]  = '{0, 0, 2'b10, 3'b100, 3'b010, 0, 2};
        tbl[9]  = '{0, 0, 2'b00, 3'b001, 3'b100, 0, 6};
        tbl[10] = '{0, 0, 2'b10, 3'b010, 3'b100, 0, 2};
        tbl[11] = '{0, 1, 2'b01, 3'b100, 3'b100, 1, 3};
        tbl[12] = '{0, 0, 2'b00, 3'b100, 3'b001, 0, 6};
        tbl[13] = '{0, 0, 2'b10, 3'b100, 3'b010, 0, 2};
        tbl[14] = '{0, 0, 2'b00, 3'b001, 3'b100, 0, 6};
        tbl[15] = '{0, 0, 2'b10, 3'b010, 3'b100, 0, 2};
        tbl[16] = '{0, 0, 2'b00, 3'b100, 3'b001, 0, 6};

        clk1();
        clk1();
        chk_out("reset", 2'b00, 3'b001, 3'b100, 1'b0);
        chk("reset time_left", Time_Left, 0);
        Sync_Reset = 1'b0;
        ph = 0;
        mode = 1;
        for (int i = 0; i < 17; i++) run_phase(tbl[i], $sformatf("phase%0d", i));

        mode = 0;
        t_base = 4'd0;
        Sync_Reprogram = 1'b1;
        clk1();
        Sync_Reprogram = 1'b0;
        ph = 0;
        mode = 1;
        chk_out("reprog", 2'b00, 3'b001, 3'b100, 1'b0);
        chk("reprog time_left", Time_Left, 0);
        clk1();
        chk("reprog settle1", Time_Left, 0);
        clk1();
        chk("reprog clamp load", Time_Left, 1);
        run_phase('{0, 0, 2'b00, 3'b001, 3'b100, 0, 1}, "zero_base");
        chk("after zero_base interval", Interval, 2'b10);

        mode = 2;
        Sync_Reprogram = 1'b1;
        for (int i = 0; i < 5; i++) begin
            clk1();
            chk($sformatf("reprog held time_left%0d", i), Time_Left, 0);
            chk($sformatf("reprog held main%0d", i), Main_Lights, 3'b001);
        end
        Sync_Reprogram = 1'b0;
        mode = 0;
        Sync_Sensor = 1'b1;
        clk1();
        Sync_Sensor = 1'b0;
        Sync_Reprogram = 1'b1;
        clk1();
        Sync_Reprogram = 1'b0;
        ph = 0;
        mode = 1;
        run_phase('{0, 0, 2'b00, 3'b001, 3'b100, 0, 1}, "latch_kept");
        chk("sensor latch kept over reprogram", Interval, 2'b01);
        t_base = 4'd6;

        n = 0;
        while (Side_Lights != 3'b001 && n < 300) begin clk1(); n++; end
        chk("reach SG", Side_Lights, 3'b001);
        n = 0;
        while (Time_Left != 4'd4 && n < 100) begin clk1(); n++; end
        chk("SG time_left 4", Time_Left, 4);
        mode = 0;
        Sync_Reset = 1'b1;
        clk1();
        Sync_Reset = 1'b0;
        chk_out("mid reset", 2'b00, 3'b001, 3'b100, 1'b0);
        chk("mid reset time_left", Time_Left, 0);

        mode = 2;
        clk1();
        chk("const tick settle1", Time_Left, 0);
        clk1();
        chk("const tick load", Time_Left, 6);
        clk1();
        chk("const tick first", Time_Left, 5);
        n = 0;
        while (Main_Lights != 3'b010 && n < 60) begin
            clk1();
            n++;
            chk("lamps onehot", $onehot(Main_Lights) && $onehot(Side_Lights) &&
                (Main_Lights == 3'b100 || Side_Lights == 3'b100), 1);
        end
        chk("const tick MG_BASE cycles", n, 5);
        chk("const MY entry time_left", Time_Left, 1);
        clk1();
        chk("const MY settle", Time_Left, 1);
        clk1();
        chk("const MY load", Time_Left, 2);
        clk1();
        chk("const MY tick", Time_Left, 1);
        clk1();
        chk("const SG main", Main_Lights, 3'b100);
        chk("const SG side", Side_Lights, 3'b001);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
